// File: rtl/mem_port_master_pkg.sv
// Shared definitions for the memory port master: bus width defaults,
// data-side FSM state encoding and a strobe helper.
package mem_port_master_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    // Data-side access sequencer states.
    typedef enum logic [1:0] {
        DST_IDLE   = 2'd0,
        DST_ACCESS = 2'd1,
        DST_RESP   = 2'd2
    } dstate_e;

    // Memory strobes for an access of the given direction, as {write, read}.
    // Exactly one of the two is ever set, so they cannot collide.
    function automatic logic [1:0] access_strobes(input logic we);
        logic [1:0] strobes;
        if (we) begin
            strobes = 2'b10;
        end else begin
            strobes = 2'b01;
        end
        return strobes;
    endfunction

endpackage

// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: owns the PC, applies branch redirects and
// qualifies the word returned by the registered instruction memory.
module ifetch_seq
    import mem_port_master_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              fetch_en_i,
    input  logic              branch_valid_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [DATA_W-1:0] i_bus_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    output logic              instr_valid_o
);

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] instr_addr_q;
    logic              instr_valid_q;

    // Next PC: a branch overrides fetching; plain fetch wraps at the top of the space.
    always_comb begin
        pc_d = pc_q;
        if (branch_valid_i) begin
            pc_d = branch_target_i;
        end else if (fetch_en_i) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and fetch qualifier registers; a branch squashes the slot it lands in.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q          <= {ADDR_W{1'b0}};
            instr_addr_q  <= {ADDR_W{1'b0}};
            instr_valid_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (branch_valid_i) begin
                instr_valid_q <= 1'b0;
            end else if (fetch_en_i) begin
                instr_valid_q <= 1'b1;
                instr_addr_q  <= pc_q;
            end else begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    // The memory already registers i_bus, so the word is passed through and
    // forced to zero whenever it is not qualified.
    assign instr_o       = instr_valid_q ? i_bus_i : {DATA_W{1'b0}};
    assign pc_o          = pc_q;
    assign instr_addr_o  = instr_addr_q;
    assign instr_valid_o = instr_valid_q;

endmodule

// File: rtl/mem_port_master.sv
// Memory port master: instruction fetch path (ifetch_seq) plus a three-state
// data access sequencer driving a shared bidirectional data bus.
module mem_port_master
    import mem_port_master_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    // fetch control
    input  logic              fetch_en,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    // data request / response
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_we,
    output logic [DATA_W-1:0] resp_rdata,
    // memory side
    output logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_bus,
    output logic [ADDR_W-1:0] d_addr,
    inout  tri   [DATA_W-1:0] d_bus,
    output logic              memory_read,
    output logic              memory_write
);

    logic [ADDR_W-1:0] pc_s;

    dstate_e           state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_we_q;
    logic              memory_read_q;
    logic              memory_write_q;

    ifetch_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ifetch (
        .clk_i           (clk),
        .reset_i         (reset),
        .fetch_en_i      (fetch_en),
        .branch_valid_i  (branch_valid),
        .branch_target_i (branch_target),
        .i_bus_i         (i_bus),
        .pc_o            (pc_s),
        .instr_o         (instr),
        .instr_addr_o    (instr_addr),
        .instr_valid_o   (instr_valid)
    );

    // Data sequencer: accept in IDLE, strobe memory for one ACCESS cycle,
    // present the response for one RESP cycle. All outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= DST_IDLE;
            we_q           <= 1'b0;
            addr_q         <= {ADDR_W{1'b0}};
            wdata_q        <= {DATA_W{1'b0}};
            rdata_q        <= {DATA_W{1'b0}};
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_we_q      <= 1'b0;
            memory_read_q  <= 1'b0;
            memory_write_q <= 1'b0;
        end else begin
            case (state_q)
                DST_IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        {memory_write_q, memory_read_q} <= access_strobes(req_we);
                        req_ready_q <= 1'b0;
                        state_q     <= DST_ACCESS;
                    end else begin
                        state_q     <= DST_IDLE;
                    end
                end
                DST_ACCESS: begin
                    memory_read_q  <= 1'b0;
                    memory_write_q <= 1'b0;
                    // Read data is only valid on the bus while memory_read is high.
                    rdata_q        <= we_q ? {DATA_W{1'b0}} : d_bus;
                    resp_we_q      <= we_q;
                    resp_valid_q   <= 1'b1;
                    state_q        <= DST_RESP;
                end
                DST_RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= DST_IDLE;
                end
                default: begin
                    state_q        <= DST_IDLE;
                    req_ready_q    <= 1'b1;
                    resp_valid_q   <= 1'b0;
                    memory_read_q  <= 1'b0;
                    memory_write_q <= 1'b0;
                end
            endcase
        end
    end

    // The bus is only driven while this port is writing; otherwise memory owns it.
    assign d_bus        = memory_write_q ? wdata_q : {DATA_W{1'bz}};

    assign i_addr       = pc_s;
    assign d_addr       = addr_q;
    assign memory_read  = memory_read_q;
    assign memory_write = memory_write_q;
    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_we      = resp_we_q;
    assign resp_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Scoreboard bench for mem_port_master: randomized fetch/branch/data traffic
// against a word-array memory model and a cycle-level reference model.
module tb_mem_port_master;

    localparam logic [15:0] IDLE_PAT = 16'h5A5A;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_we;
    logic [15:0] resp_rdata;
    logic [15:0] i_addr;
    logic [15:0] i_bus;
    logic [15:0] d_addr;
    tri   [15:0] d_bus;
    logic        memory_read;
    logic        memory_write;

    mem_port_master #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .fetch_en(fetch_en), .branch_valid(branch_valid), .branch_target(branch_target),
        .instr(instr), .instr_addr(instr_addr), .instr_valid(instr_valid),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_we(resp_we), .resp_rdata(resp_rdata),
        .i_addr(i_addr), .i_bus(i_bus), .d_addr(d_addr), .d_bus(d_bus),
        .memory_read(memory_read), .memory_write(memory_write)
    );

    always #5 clk = ~clk;

    // Initial memory image: fixed program words at 0..2, hashed elsewhere.
    function automatic logic [15:0] init_val(input int a);
        case (a)
            0:       init_val = 16'hFF1A;
            1:       init_val = 16'hAAAA;
            2:       init_val = 16'hFF3A;
            default: init_val = 16'(a * 40503) ^ 16'h3C5A;
        endcase
    endfunction

    // ---------------- memory model ----------------
    logic [15:0] mem [0:65535];
    logic        mem_loaded = 1'b0;
    logic [15:0] mem_rd;

    // Registered instruction port and write-at-edge data port.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (memory_write) begin
            mem[d_addr] <= d_bus;
        end
        i_bus <= mem[i_addr];
    end

    // Combinational read data; a known idle pattern when nobody owns the bus.
    always @* mem_rd = mem[d_addr];
    assign d_bus = memory_write ? 16'hzzzz : (memory_read ? mem_rd : IDLE_PAT);

    // ---------------- reference model / scoreboard ----------------
    typedef struct { int due; logic [15:0] addr; logic [15:0] data; } fexp_t;
    typedef struct { int due; logic we; logic [15:0] data; } rexp_t;

    fexp_t       fq[$];
    rexp_t       rq[$];
    logic [15:0] ref_mem [0:65535];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        chk_en = 1'b0;
    logic [15:0] pc_m = 16'h0000;
    logic [15:0] exp_pc = 16'h0000;
    logic        exp_ready = 1'b1;
    int          last_acc = -100;
    int          acc_cyc = -1;
    logic        acc_we = 1'b0;
    logic [15:0] acc_addr = 16'h0000;
    logic [15:0] acc_wdata = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and record what the design owes in response.
    task automatic apply(input logic fe, input logic bv, input logic [15:0] bt,
                         input logic rv, input logic rwe, input logic [15:0] ra,
                         input logic [15:0] rwd, output logic accepted);
        fetch_en = fe; branch_valid = bv; branch_target = bt;
        req_valid = rv; req_we = rwe; req_addr = ra; req_wdata = rwd;
        exp_pc    = pc_m;
        exp_ready = (cyc - last_acc) >= 3;
        accepted  = rv && exp_ready;
        if (bv) begin
            pc_m = bt;
        end else if (fe) begin
            fq.push_back('{due: cyc + 1, addr: pc_m, data: ref_mem[pc_m]});
            pc_m = pc_m + 16'd1;
        end
        if (accepted) begin
            last_acc  = cyc;
            acc_cyc   = cyc + 1;
            acc_we    = rwe;
            acc_addr  = ra;
            acc_wdata = rwd;
            rq.push_back('{due: cyc + 2, we: rwe, data: rwe ? 16'h0000 : ref_mem[ra]});
            if (rwe) ref_mem[ra] = rwd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic d;
        for (int k = 0; k < n; k++) apply(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, d);
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] wd);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) apply(1'b0, 1'b0, 16'h0, 1'b1, we, a, wd, got);
        if (!got) chk("issue_timeout", 32'(got), 32'd1);
    endtask

    // Reset with every other input active, then check the reset values.
    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b1; fetch_en = 1'b1; branch_valid = 1'b1; branch_target = 16'h0123;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h8000; req_wdata = 16'hFFFF;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0; fetch_en = 1'b0; branch_valid = 1'b0; branch_target = 16'h0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        fq.delete(); rq.delete();
        pc_m = 16'h0; exp_pc = 16'h0; exp_ready = 1'b1; last_acc = -100;
        acc_cyc = -1; acc_we = 1'b0; acc_addr = 16'h0; acc_wdata = 16'h0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_addr", 32'(instr_addr), 32'd0);
        chk("rst_i_addr", 32'(i_addr), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_we", 32'(resp_we), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_d_addr", 32'(d_addr), 32'd0);
        chk("rst_memory_read", 32'(memory_read), 32'd0);
        chk("rst_memory_write", 32'(memory_write), 32'd0);
        chk("rst_d_bus_hiz", 32'(d_bus), 32'(IDLE_PAT));
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle interface rules plus in-order scoreboard pops.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("i_addr", 32'(i_addr), 32'(exp_pc));
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("memory_read", 32'(memory_read), 32'((cyc == acc_cyc) && !acc_we));
            chk("memory_write", 32'(memory_write), 32'((cyc == acc_cyc) && acc_we));
            if (cyc == acc_cyc || cyc == acc_cyc + 1) chk("d_addr", 32'(d_addr), 32'(acc_addr));
            if (cyc == acc_cyc && acc_we) chk("d_bus_wdata", 32'(d_bus), 32'(acc_wdata));
            if (!memory_write && !memory_read) chk("d_bus_hiz", 32'(d_bus), 32'(IDLE_PAT));
            if (fq.size() != 0 && fq[0].due == cyc) begin
                chk("instr_valid", 32'(instr_valid), 32'd1);
                if (instr_valid) begin
                    chk("instr_addr", 32'(instr_addr), 32'(fq[0].addr));
                    chk("instr", 32'(instr), 32'(fq[0].data));
                end
                fq.delete(0);
            end else begin
                chk("instr_valid", 32'(instr_valid), 32'd0);
            end
            if (rq.size() != 0 && rq[0].due == cyc) begin
                chk("resp_valid", 32'(resp_valid), 32'd1);
                if (resp_valid) begin
                    chk("resp_we", 32'(resp_we), 32'(rq[0].we));
                    chk("resp_rdata", 32'(resp_rdata), 32'(rq[0].data));
                end
                rq.delete(0);
            end else begin
                chk("resp_valid", 32'(resp_valid), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic d;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        do_reset();

        // Sequential fetch 0..4, then a branch to 0x0040 issued at PC 5.
        for (int k = 0; k < 5; k++) apply(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, d);
        apply(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, d);
        apply(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, d);
        idle(1);

        // Wrap from 0xFFFF to 0x0000.
        apply(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0, d);
        apply(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, d);
        apply(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, d);
        idle(1);

        // Store then load the same word.
        issue(1'b1, 16'h1000, 16'hAAAA);
        issue(1'b0, 16'h1000, 16'h0000);
        idle(3);

        // req_valid held high continuously.
        for (int k = 0; k < 12; k++)
            apply(1'b0, 1'b0, 16'h0, 1'b1, 1'($urandom_range(0, 1)),
                  16'h8000 + 16'($urandom_range(0, 15)), 16'($urandom), d);

        // Random concurrent fetch / branch / data traffic.
        for (int k = 0; k < 600; k++)
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  16'($urandom_range(256, 3072)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'h8000 + 16'($urandom_range(0, 15)), 16'($urandom), d);
        idle(4);
        chk("fetch_drained", 32'(fq.size()), 32'd0);
        chk("resp_drained", 32'(rq.size()), 32'd0);

        // Reset arrives in the ACCESS cycle of a store.
        issue(1'b1, 16'h0020, 16'h1234);
        do_reset();
        chk("rst_store_commit", 32'(mem[16'h0020]), 32'h1234);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
